// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, response codes and FSM state types.
// No logic: types and constants only.
// Imported by the register slave.
package axi_lite_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Captured write request, filled independently by the AW and W handshakes.
  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } wr_req_t;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; RO slots return hw_status.
// Latency: bvalid 1 cycle after the later of AW/W; rvalid right after the AR handshake edge.
// Backpressure: one outstanding txn per direction; ready stays low until B/R is taken.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                     NUM_REGS  = 16,
  parameter logic [AXIL_ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter logic [NUM_REGS-1:0]    RO_MASK   = '0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [AXIL_ADDR_W-1:0]          awaddr,
  input  logic [2:0]                      awprot,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [AXIL_STRB_W-1:0]          wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [AXIL_ADDR_W-1:0]          araddr,
  input  logic [2:0]                      arprot,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*AXIL_DATA_W-1:0] hw_status,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [AXIL_DATA_W-1:0] regs     [NUM_REGS];
  logic [AXIL_DATA_W-1:0] status_w [NUM_REGS];

  wr_state_t w_state, w_state_nxt;
  rd_state_t r_state, r_state_nxt;

  logic       rdy_en;
  logic       aw_got, w_got;
  wr_req_t    wr_q;
  resp_t      bresp_q, rresp_q;
  logic [AXIL_DATA_W-1:0] rdata_q;

  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic       w_hit, w_ro, r_hit, r_ro;
  logic [IDX_W-1:0] w_idx, r_idx;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[AXIL_DATA_W*i +: AXIL_DATA_W] = regs[i];
    assign status_w[i] = hw_status[AXIL_DATA_W*i +: AXIL_DATA_W];
  end

  // Word index relative to BASE_ADDR; byte offset bits are dropped by the shift.
  function automatic void decode(input  logic [AXIL_ADDR_W-1:0] addr,
                                 output logic                   hit,
                                 output logic                   ro,
                                 output logic [IDX_W-1:0]       idx);
    logic [AXIL_ADDR_W-1:0] word;
    word = (addr - BASE_ADDR) >> 2;
    hit  = (addr >= BASE_ADDR) && (word < AXIL_ADDR_W'(NUM_REGS));
    idx  = word[IDX_W-1:0];
    ro   = hit && RO_MASK[idx];
  endfunction

  always_comb decode(wr_q.addr, w_hit, w_ro, w_idx);
  always_comb decode(araddr, r_hit, r_ro, r_idx);

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign commit = (w_state == W_IDLE) && aw_got && w_got;

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (aw_got && w_got) w_state_nxt = W_RESP;
      W_RESP: if (b_hs)            w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (w_state == W_IDLE) begin
      awready = rdy_en && !aw_got;
      wready  = rdy_en && !w_got;
    end else begin
      bvalid  = 1'b1;
    end
  end

  assign bresp = bresp_q;

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
      R_DATA: if (r_hs)  r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = rdy_en && (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  // ---------------- datapath ----------------
  // rdy_en keeps every ready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en   <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wr_q     <= '0;
      bresp_q  <= OKAY;
      wr_pulse <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rdy_en   <= 1'b1;
      wr_pulse <= '0;

      if (aw_hs) begin
        aw_got    <= 1'b1;
        wr_q.addr <= awaddr;
      end
      if (w_hs) begin
        w_got     <= 1'b1;
        wr_q.data <= wdata;
        wr_q.strb <= wstrb;
      end

      if (commit) begin
        if (w_hit && !w_ro) begin
          for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (wr_q.strb[b]) regs[w_idx][8*b +: 8] <= wr_q.data[8*b +: 8];
          end
          wr_pulse[w_idx] <= 1'b1;
          bresp_q         <= OKAY;
        end else begin
          bresp_q         <= SLVERR;
        end
      end

      if (b_hs) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end

      // Sampled on the handshake edge, so a same-edge write commit is not yet visible.
      if (ar_hs) begin
        if (!r_hit) begin
          rdata_q <= '0;
          rresp_q <= SLVERR;
        end else begin
          rdata_q <= r_ro ? status_w[r_idx] : regs[r_idx];
          rresp_q <= OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a reference register model and response queues.
module tb_axi_lite_reg_slave;

  localparam int          NREG   = 16;
  localparam logic [15:0] RO_TB  = 16'h0004;

  logic         aclk;
  logic         aresetn;
  logic [31:0]  awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] reg_q;
  logic [511:0] hw_status;
  logic [15:0]  wr_pulse;

  axi_lite_reg_slave #(.NUM_REGS(NREG), .BASE_ADDR(32'h0), .RO_MASK(RO_TB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .hw_status(hw_status), .wr_pulse(wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] data;
  } exp_t;

  exp_t        bq[$];
  exp_t        rq[$];
  logic [31:0] model     [NREG];
  logic [31:0] status_tb [NREG];
  int          checks;
  int          failures;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_vec();
    logic [511:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic apply_reset();
    #1 aresetn = 1'b0;
    #1;
    check("rst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse}, '0);
    check("rst_reg_q", reg_q, '0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    bq.delete();
    rq.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_ready_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    check("rst_ready_after_edge", {awready, wready, arready}, 3'b111);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall, input bit abandon);
    exp_t        e;
    bit          aw_done, w_done, aw_hs, w_hs, stable, ok;
    int          t, lat;
    logic [1:0]  b0;
    logic [15:0] p1;
    logic [3:0]  widx;
    widx    = addr[5:2];
    ok      = (addr < 32'h40) && !RO_TB[widx];
    e.resp  = ok ? 2'b00 : 2'b10;
    e.pulse = ok ? (16'h1 << widx) : 16'h0;
    e.data  = data;
    bq.push_back(e);

    @(posedge aclk); #1;
    awaddr = addr; wdata = data; wstrb = strb;
    bready = (b_stall == 0) && !abandon;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_handshake", aw_done && w_done, 1);

    lat = 0;
    @(negedge aclk);
    while (!bvalid && lat < 20) begin
      lat++;
      @(negedge aclk);
    end
    check("b_latency", lat, 1);
    e = bq.pop_front();
    check("bresp", bresp, e.resp);
    check("wr_pulse", wr_pulse, e.pulse);
    if (e.resp == 2'b00)
      for (int b = 0; b < 4; b++) if (strb[b]) model[widx][8*b +: 8] = data[8*b +: 8];
    if (abandon) return;

    b0 = bresp;
    if (b_stall > 0) begin
      awvalid = 1'b1; wvalid = 1'b1; stable = 1'b1; p1 = '1;
      for (int i = 0; i < b_stall; i++) begin
        @(posedge aclk); #1;
        @(negedge aclk);
        if (i == 0) p1 = wr_pulse;
        if (!bvalid || bresp !== b0 || awready || wready) stable = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      check("b_stall_stable", stable, 1);
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
    end else begin
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      p1 = wr_pulse;
    end
    check("wr_pulse_one_cycle", p1, 0);
    check("b_done_idle", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_stall);
    exp_t        e;
    bit          done, hs, stable;
    int          t, lat;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic [3:0]  ridx;
    ridx    = addr[5:2];
    e.pulse = '0;
    if (addr >= 32'h40) begin
      e.data = '0;             e.resp = 2'b10;
    end else if (RO_TB[ridx]) begin
      e.data = status_tb[ridx]; e.resp = 2'b00;
    end else begin
      e.data = model[ridx];     e.resp = 2'b00;
    end
    rq.push_back(e);

    @(posedge aclk); #1;
    araddr = addr;
    rready = (r_stall == 0);
    done = 1'b0; t = 0;
    while (!done && t < 40) begin
      arvalid = (t >= ar_dly);
      @(negedge aclk);
      hs = arvalid && arready;
      @(posedge aclk); #1;
      done = hs;
      t++;
    end
    arvalid = 1'b0;
    check("ar_handshake", done, 1);

    lat = 0;
    @(negedge aclk);
    while (!rvalid && lat < 20) begin
      lat++;
      @(negedge aclk);
    end
    check("r_latency", lat, 0);
    e = rq.pop_front();
    check("rresp", rresp, e.resp);
    check("rdata", rdata, e.data);

    d0 = rdata; r0 = rresp;
    if (r_stall > 0) begin
      arvalid = 1'b1; araddr = addr ^ 32'h4; stable = 1'b1;
      for (int i = 0; i < r_stall; i++) begin
        @(posedge aclk); #1;
        @(negedge aclk);
        if (!rvalid || rdata !== d0 || rresp !== r0 || arready) stable = 1'b0;
      end
      arvalid = 1'b0; rready = 1'b1;
      check("r_stall_stable", stable, 1);
    end
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    check("r_done_idle", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    checks = 0; failures = 0;
    aresetn = 1'b1;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      status_tb[i] = 32'h5A00_0000 | 32'(i);
      model[i]     = '0;
    end
    status_tb[2] = 32'h0000_A5A5;
    for (int i = 0; i < NREG; i++) hw_status[32*i +: 32] = status_tb[i];

    apply_reset();

    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 3, 0, 0);
    check("reg1_deadbeef", reg_q[32*1 +: 32], 32'hDEADBEEF);

    axi_write(32'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    axi_write(32'h14, 32'h11223344, 4'b0101, 2, 0, 0, 0);
    check("reg5_strb_merge", reg_q[32*5 +: 32], 32'hFF22FF44);

    axi_read(32'h40, 0, 0);
    axi_read(32'h4, 0, 0);

    axi_write(32'h40, 32'h0BADF00D, 4'hF, 1, 1, 0, 0);
    check("oob_write_no_update", reg_q, model_vec());

    axi_read(32'h8, 0, 0);
    axi_write(32'h8, 32'h12345678, 4'hF, 0, 0, 0, 0);
    check("ro_write_no_update", reg_q, model_vec());

    axi_write(32'hC, 32'h0C0C0C0C, 4'hF, 0, 0, 5, 0);
    axi_read(32'h14, 1, 5);

    axi_write(32'h0, 32'h12345678, 4'hF, 0, 0, 0, 0);
    fork
      axi_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
      axi_read(32'h0, 1, 0);
    join
    axi_read(32'h0, 0, 0);

    axi_write(32'h4, 32'h0, 4'h0, 0, 0, 0, 0);
    check("strb0_unchanged", reg_q[32*1 +: 32], 32'hDEADBEEF);

    axi_write(32'h1B, 32'h600DCAFE, 4'hF, 0, 0, 0, 0);
    axi_read(32'h19, 0, 0);
    check("regs_vs_model", reg_q, model_vec());

    axi_write(32'hC, 32'h77777777, 4'hF, 0, 0, 0, 1);
    check("pre_reset_bvalid", bvalid, 1);
    apply_reset();
    axi_write(32'h24, 32'h13579BDF, 4'hF, 1, 0, 0, 0);
    axi_read(32'h24, 0, 0);
    check("post_reset_regs", reg_q, model_vec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
